// File: rtl/uart_pkg.sv
// Shared types and baud arithmetic for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } rx_state_e;

  function automatic int calc_baud_cnt_max(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  function automatic int calc_mid(input int baud_cnt_max);
    return baud_cnt_max / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_ext_if.sv
// Received-word handshake bundle: the receiver drives the master side,
// the consumer drives po_ready from the slave side.
interface uart_rx_ext_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] po_data;
  logic                 po_valid;
  logic                 po_ready;
  logic                 po_frame_err;
  logic                 po_par_err;
  logic                 overrun;

  modport master (
    output po_data, po_valid, po_frame_err, po_par_err, overrun,
    input  po_ready
  );

  modport slave (
    input  po_data, po_valid, po_frame_err, po_par_err, overrun,
    output po_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Baud counter plus 2-of-3 majority vote around the bit centre.
// Counter is held at zero while en_i is low; bit_tick fires at MID+1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en_i,
  input  logic rx_sync_i,
  output logic bit_tick,
  output logic bit_val
);

  localparam int BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int MID          = calc_mid(BAUD_CNT_MAX);
  localparam int CNT_W        = $clog2(BAUD_CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(MID + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       samp_q, samp_d;

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_comb begin
    cnt_d  = '0;
    samp_d = samp_q;
    if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == SAMP_A) samp_d[0] = rx_sync_i;
      if (cnt_q == SAMP_B) samp_d[1] = rx_sync_i;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q  <= '0;
      samp_q <= 2'b11;
    end else begin
      cnt_q  <= cnt_d;
      samp_q <= samp_d;
    end
  end

  // Third vote is the live synchronised line at the tick count itself.
  assign bit_tick = en_i && (cnt_q == SAMP_C);
  assign bit_val  = vote3(samp_q[0], samp_q[1], rx_sync_i);

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with majority sampling, framing/parity flags and a
// non-stalling valid/ready output. Optional parity stage: UART_RX_PARITY_EN.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            rx,
  uart_rx_ext_if.master   po_if
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  logic rx_meta_q, rx_sync_q, rx_hist_q;
  logic start_cond, bit_tick, bit_val, frame_done;

  rx_state_e            state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 operr_q, operr_d;
`endif

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 oferr_q, oferr_d;
  logic                 ovr_q, ovr_d;

  assign start_cond = rx_hist_q & ~rx_sync_q;

  uart_rx_sampler #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_sampler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en_i      (state_q != IDLE),
    .rx_sync_i (rx_sync_q),
    .bit_tick  (bit_tick),
    .bit_val   (bit_val)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
`endif
    case (state_q)
      IDLE:  if (start_cond) state_d = START;
      START: if (bit_tick) begin
        if (bit_val) begin
          state_d = IDLE;
        end else begin
          state_d   = DATA;
          bit_cnt_d = '0;
          ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d    = 1'b0;
`endif
        end
      end
      DATA: if (bit_tick) begin
        shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_LAST) begin
          stop_cnt_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          state_d    = PARITY;
`else
          state_d    = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_tick) begin
        perr_d  = ((^shift_q) ^ bit_val) != PARITY_ODD[0];
        state_d = STOP;
      end
`endif
      STOP: if (bit_tick) begin
        ferr_d     = ferr_q | ~bit_val;
        stop_cnt_d = stop_cnt_q + 1'b1;
        if (stop_cnt_q == STOP_LAST) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completed frame loads only if the output slot is free or being drained.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    oferr_d = oferr_q;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    operr_d = operr_q;
`endif
    if (valid_q && po_if.po_ready) valid_d = 1'b0;
    if (frame_done) begin
      if (!valid_q || po_if.po_ready) begin
        data_d  = shift_q;
        oferr_d = ferr_d;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        operr_d = perr_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_hist_q  <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      oferr_q    <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      operr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_hist_q  <= rx_sync_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      oferr_q    <= oferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      operr_q    <= operr_d;
`endif
    end
  end

  assign po_if.po_data      = data_q;
  assign po_if.po_valid     = valid_q;
  assign po_if.po_frame_err = oferr_q;
  assign po_if.overrun      = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign po_if.po_par_err   = operr_q;
`else
  // Without a parity stage the sense parameter has no influence on the flag.
  assign po_if.po_par_err   = 1'b0 & PARITY_ODD[0];
`endif

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext at 50 MHz / 115200 baud (434 clocks per bit).
// Parity steps are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_ext;
  import uart_pkg::*;

  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 115200;
  localparam int BIT      = 434;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic rx        = 1'b1;

  uart_rx_ext_if #(.DATA_BITS(8)) po_if ();

  uart_rx_ext #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BPS   (UART_BPS),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .PARITY_ODD (0)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx        (rx),
    .po_if     (po_if)
  );

  always #10 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  int         n_valid_cyc = 0;
  int         n_acc       = 0;
  int         n_ovr       = 0;
  logic [7:0] cap_data    = 8'h00;
  logic       cap_ferr    = 1'b0;
  logic       cap_perr    = 1'b0;
  int         b_acc, b_ovr, b_vc;
`ifdef UART_RX_PARITY_EN
  logic       par_flip    = 1'b0;
`endif

  always @(negedge sys_clk) begin
    if (po_if.po_valid) n_valid_cyc <= n_valid_cyc + 1;
    if (po_if.po_valid && po_if.po_ready) begin
      n_acc    <= n_acc + 1;
      cap_data <= po_if.po_data;
      cap_ferr <= po_if.po_frame_err;
      cap_perr <= po_if.po_par_err;
    end
    if (po_if.overrun) n_ovr <= n_ovr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(BIT);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_b);
    rx = 1'b1;
    step(2 * BIT);
  endtask

  task automatic snap();
    b_acc = n_acc;
    b_ovr = n_ovr;
    b_vc  = n_valid_cyc;
  endtask

  initial begin
    po_if.po_ready = 1'b1;
    step(5);
    check("rst_valid", 32'(po_if.po_valid), 32'd0);
    check("rst_data", 32'(po_if.po_data), 32'h00);
    check("rst_ferr", 32'(po_if.po_frame_err), 32'd0);
    check("rst_perr", 32'(po_if.po_par_err), 32'd0);
    check("rst_ovr", 32'(po_if.overrun), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    sys_rst_n = 1'b1;
    step(5);

    // Plain 8N1 word
    snap();
    send_frame(8'hA5, 1'b1);
    check("a5_count", 32'(n_acc - b_acc), 32'd1);
    check("a5_pulse_len", 32'(n_valid_cyc - b_vc), 32'd1);
    check("a5_data", 32'(cap_data), 32'hA5);
    check("a5_ferr", 32'(cap_ferr), 32'd0);
    check("a5_perr", 32'(cap_perr), 32'd0);
    check("a5_ovr", 32'(n_ovr - b_ovr), 32'd0);
    check("a5_valid_after", 32'(po_if.po_valid), 32'd0);

    // Short low glitch must be rejected as a false start
    snap();
    rx = 1'b0;
    step(100);
    rx = 1'b1;
    step(600);
    check("glitch_count", 32'(n_acc - b_acc), 32'd0);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));

    // Stop bit low
    snap();
    send_frame(8'h3C, 1'b0);
    check("fe_count", 32'(n_acc - b_acc), 32'd1);
    check("fe_data", 32'(cap_data), 32'h3C);
    check("fe_ferr", 32'(cap_ferr), 32'd1);

    // Clean frame after a framing error
    snap();
    send_frame(8'hC3, 1'b1);
    check("recov_count", 32'(n_acc - b_acc), 32'd1);
    check("recov_data", 32'(cap_data), 32'hC3);
    check("recov_ferr", 32'(cap_ferr), 32'd0);

`ifdef UART_RX_PARITY_EN
    snap();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    check("par_bad_data", 32'(cap_data), 32'h07);
    check("par_bad_perr", 32'(cap_perr), 32'd1);
    snap();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    check("par_ok_count", 32'(n_acc - b_acc), 32'd1);
    check("par_ok_perr", 32'(cap_perr), 32'd0);
`endif

    // Back-pressure: second word is dropped with a single overrun pulse
    po_if.po_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1);
    check("ovr1_valid", 32'(po_if.po_valid), 32'd1);
    check("ovr1_data", 32'(po_if.po_data), 32'h11);
    check("ovr1_cnt", 32'(n_ovr - b_ovr), 32'd0);
    send_frame(8'h22, 1'b1);
    check("ovr2_valid", 32'(po_if.po_valid), 32'd1);
    check("ovr2_data", 32'(po_if.po_data), 32'h11);
    check("ovr2_cnt", 32'(n_ovr - b_ovr), 32'd1);
    po_if.po_ready = 1'b1;
    step(1);
    check("drain_valid", 32'(po_if.po_valid), 32'd0);
    check("drain_count", 32'(n_acc - b_acc), 32'd1);
    check("drain_data", 32'(cap_data), 32'h11);

    // Reset mid-data of 0x55, released during the stop bit
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    step(BIT / 2);
    check("mid_state", 32'(dut.state_q), 32'(DATA));
    sys_rst_n = 1'b0;
    #1;
    check("arst_state", 32'(dut.state_q), 32'(IDLE));
    check("arst_data", 32'(po_if.po_data), 32'h00);
    check("arst_valid", 32'(po_if.po_valid), 32'd0);
    step(BIT / 2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    step(BIT / 2);
    sys_rst_n = 1'b1;
    step(BIT / 2 + 2 * BIT);
    check("arst_no_word", 32'(n_acc - b_acc), 32'd0);
    send_frame(8'h66, 1'b1);
    check("post_rst_count", 32'(n_acc - b_acc), 32'd1);
    check("post_rst_data", 32'(cap_data), 32'h66);
    check("post_rst_ferr", 32'(cap_ferr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 9600, line baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-005 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-006 SHALL have port sys_clk, input, 1 bit, system clock; all logic on the rising edge.
REQ-007 SHALL have port sys_rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port rx, input, 1 bit, asynchronous serial line; idles high.
REQ-009 SHALL have port po_data, output, DATA_BITS wide, received word, LSB = first data bit on the line.
REQ-010 SHALL have port po_valid, output, 1 bit, po_data/po_frame_err/po_par_err valid.
REQ-011 SHALL have port po_ready, input, 1 bit, consumer accepts the word.
REQ-012 SHALL have port po_frame_err, output, 1 bit, any checked stop bit sampled low.
REQ-013 SHALL have port po_par_err, output, 1 bit, parity mismatch.
REQ-014 SHALL have port overrun, output, 1 bit, one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL synchronise rx through two flops plus one history flop (all reset to 1); start condition = synchronised falling edge while in IDLE.
REQ-016 SHALL define BAUD_CNT_MAX = CLK_FREQ/UART_BPS and MID = BAUD_CNT_MAX/2 - 1.
REQ-017 SHALL size the baud counter as $clog2(BAUD_CNT_MAX); the counter wraps BAUD_CNT_MAX-1 -> 0 and is held at 0 in IDLE.
REQ-018 SHALL decide each bit by 2-of-3 majority of synchronised rx at baud counts MID-1, MID and MID+1; the bit tick is asserted at MID+1.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with transitions:
- IDLE -> START on start condition.
- START -> IDLE if the start bit votes 1 (false start: no output, no flags).
- START -> DATA if the start bit votes 0.
- DATA -> PARITY (parity compiled in) or STOP after DATA_BITS ticks.
- PARITY -> STOP after one tick.
- STOP -> IDLE after STOP_BITS ticks.
REQ-020 SHALL shift data LSB-first; the bit counter resets to 0 on entry to DATA.
REQ-021 SHALL set po_frame_err if any checked stop bit votes 0; after a framing error the FSM returns to IDLE and requires a fresh falling edge.
REQ-022 SHALL, on the final stop tick, load po_data and both error flags on the next cycle and assert po_valid on that cycle (latency = 1 clock after final stop tick).
REQ-023 SHALL hold po_valid, po_data and the error flags stable until the cycle with po_valid && po_ready; po_valid then deasserts on the next cycle unless a new word loads on that same cycle.
REQ-024 SHALL treat a new frame completing while po_valid && !po_ready as follows: drop the new word, keep the old word, pulse overrun for 1 cycle.
REQ-025 SHALL treat a new frame completing on the same cycle as a handshake as a normal accept-and-load: po_valid stays high, no overrun.
REQ-026 SHALL begin receiving the next frame regardless of po_valid; the receiver never stalls.

Reset
REQ-027 SHALL, on sys_rst_n low, immediately force: FSM to IDLE, counters to 0, po_data to 0, po_valid/po_frame_err/po_par_err/overrun to 0, sync flops to 1.
REQ-028 SHALL, after reset deasserts mid-frame, wait for a new falling edge; no partial word is output.

Configuration
REQ-029 SHALL provide macro UART_RX_PARITY_EN.
- Defined: PARITY state included; parity bit checked per PARITY_ODD; a mismatch sets po_par_err.
- Undefined: PARITY state and checker absent; DATA -> STOP directly; po_par_err tied to 0; PARITY_ODD ignored.

Structure
REQ-030 SHALL place the FSM state enum and the BAUD_CNT_MAX/MID computation functions in package uart_pkg.
REQ-031 SHALL implement the baud counter and 3-point majority sampler as sub-module uart_rx_sampler, which outputs bit_tick and bit_val.

Verification (CLK_FREQ=50_000_000, UART_BPS=115200, BAUD_CNT_MAX=434, po_ready=1 unless stated)
REQ-032 SHALL verify 8N1 frame 0xA5 -> po_valid pulse with po_data=0xA5, no errors.
REQ-033 SHALL verify a 100-clock low glitch on idle rx -> no po_valid, FSM back in IDLE.
REQ-034 SHALL verify stop bit driven low on 0x3C -> po_data=0x3C, po_frame_err=1.
REQ-035 SHALL verify, with UART_RX_PARITY_EN and PARITY_ODD=0, 0x07 sent with parity bit 0 -> po_par_err=1; with parity bit 1 -> po_par_err=0.
REQ-036 SHALL verify po_ready=0 while two frames 0x11 then 0x22 arrive -> po_data stays 0x11, overrun pulses once at end of 0x22.
REQ-037 SHALL verify sys_rst_n asserted mid-data of 0x55, then 0x66 sent -> only 0x66 output.
